// File: rtl/pmem_write_buffer.sv
// Line-granular eviction write buffer sitting between the victim cache's
// memory-side port and physical memory. Writebacks are absorbed into a
// small FIFO of lines and complete upstream in one cycle. Read misses go to
// memory ahead of queued writebacks. Reads that hit a buffered line are
// answered from the buffer, so memory never returns a stale copy.
//
// Handshake: upstream read/write are held until the one-cycle resp pulse.
// pmem_read/pmem_write are held until the one-cycle pmem_resp pulse. At
// most one of pmem_read/pmem_write is high at any time.
module pmem_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128,
    parameter int OFFS_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [LINE_W-1:0] wdata,
    output logic              resp,
    output logic [LINE_W-1:0] rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata,
    output logic              full,
    output logic              empty
);

    localparam int TAG_W = ADDR_W - OFFS_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {UIDLE, URESP, UREAD, UBLANK} ustate_t;
    typedef enum logic       {DIDLE, DWRITE}               dstate_t;

    ustate_t ustate;
    dstate_t dstate;

    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [LINE_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic [TAG_W-1:0]  req_tag;
    logic              rd_hit;
    logic [PTR_W-1:0]  rd_idx;
    logic [PTR_W-1:0]  rd_pos;
    logic              wr_hit;
    logic [PTR_W-1:0]  wr_idx;
    logic [PTR_W-1:0]  wr_pos;
    logic              enter_read;
    logic              drain_start;
    logic              draining;
    logic              push;
    logic              coalesce;
    logic              pop;

    assign req_tag = address[ADDR_W-1:OFFS_W];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);

    // Read lookup: newest valid entry whose tag matches, head included.
    always_comb begin
        rd_hit = 1'b0;
        rd_idx = '0;
        rd_pos = '0;
        for (int k = 0; k < DEPTH; k++) begin
            rd_pos = head + PTR_W'(k);
            if ((CNT_W'(k) < count) && (tag_q[rd_pos] == req_tag)) begin
                rd_hit = 1'b1;
                rd_idx = rd_pos;
            end
        end
    end

    // Drain launch: reads win, so a read miss entering or waiting blocks it.
    always_comb begin
        enter_read  = (ustate == UIDLE) && read && !write && !rd_hit;
        drain_start = (dstate == DIDLE) && (count != '0)
                      && (ustate != UREAD) && !enter_read;
        draining    = (dstate == DWRITE) || drain_start;
    end

    // Write lookup: a matching entry may absorb new data unless it is the
    // head currently being (or about to be) written to memory.
    always_comb begin
        wr_hit = 1'b0;
        wr_idx = '0;
        wr_pos = '0;
        for (int k = 0; k < DEPTH; k++) begin
            wr_pos = head + PTR_W'(k);
            if ((CNT_W'(k) < count) && (tag_q[wr_pos] == req_tag)
                && !(draining && (k == 0))) begin
                wr_hit = 1'b1;
                wr_idx = wr_pos;
            end
        end
    end

    // Storage events for this cycle.
    always_comb begin
        coalesce = (ustate == UIDLE) && write && wr_hit;
        push     = (ustate == UIDLE) && write && !wr_hit && !full;
        pop      = (dstate == DWRITE) && pmem_resp;
    end

    // Line storage: push writes at tail, coalesce overwrites a queued entry.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_q[tail]  <= req_tag;
            data_q[tail] <= wdata;
        end
        if (coalesce) begin
            data_q[wr_idx] <= wdata;
        end
    end

    // Pointers, count, upstream FSM and drain FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            ustate       <= UIDLE;
            dstate       <= DIDLE;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            resp         <= 1'b0;
            rdata        <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end

            case (ustate)
                UIDLE: begin
                    if (write) begin
                        if (coalesce || push) begin
                            resp   <= 1'b1;
                            ustate <= URESP;
                        end
                    end else if (read) begin
                        if (rd_hit) begin
                            rdata  <= data_q[rd_idx];
                            resp   <= 1'b1;
                            ustate <= URESP;
                        end else begin
                            ustate <= UREAD;
                        end
                    end
                end
                UREAD: begin
                    if (pmem_read) begin
                        if (pmem_resp) begin
                            rdata     <= pmem_rdata;
                            pmem_read <= 1'b0;
                            resp      <= 1'b1;
                            ustate    <= URESP;
                        end
                    end else if (dstate == DIDLE) begin
                        pmem_read    <= 1'b1;
                        pmem_address <= address;
                    end
                end
                URESP: begin
                    resp   <= 1'b0;
                    ustate <= UBLANK;
                end
                UBLANK: begin
                    ustate <= UIDLE;
                end
                default: begin
                    ustate <= UIDLE;
                end
            endcase

            case (dstate)
                DIDLE: begin
                    if (drain_start) begin
                        pmem_write   <= 1'b1;
                        pmem_address <= {tag_q[head], {OFFS_W{1'b0}}};
                        pmem_wdata   <= data_q[head];
                        dstate       <= DWRITE;
                    end
                end
                DWRITE: begin
                    if (pmem_resp) begin
                        pmem_write <= 1'b0;
                        dstate     <= DIDLE;
                    end
                end
                default: begin
                    dstate <= DIDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmem_write_buffer.sv
// Bench for pmem_write_buffer: a table of buffered read/write operations
// with hand-computed results, plus directed sequences for stalls, read
// priority, coalescing and reset. Drained lines are compared against an
// expected queue of {address, data}.
module tb_pmem_write_buffer;
  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;
  localparam int W = ADDR_W + LINE_W;

  logic clk = 1'b0;
  logic reset;
  logic read;
  logic write;
  logic [ADDR_W-1:0] address;
  logic [LINE_W-1:0] wdata;
  logic resp;
  logic [LINE_W-1:0] rdata;
  logic pmem_read;
  logic pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic pmem_resp;
  logic [LINE_W-1:0] pmem_rdata;
  logic full;
  logic empty;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    bit is_wr;
    logic [ADDR_W-1:0] a;
    logic [LINE_W-1:0] d;
    logic [LINE_W-1:0] exp_rd;
    bit exp_full;
    bit exp_empty;
  } vec_t;

  vec_t tbl[12];

  pmem_write_buffer dut (
    .clk(clk),
    .reset(reset),
    .read(read),
    .write(write),
    .address(address),
    .wdata(wdata),
    .resp(resp),
    .rdata(rdata),
    .pmem_read(pmem_read),
    .pmem_write(pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp),
    .pmem_rdata(pmem_rdata),
    .full(full),
    .empty(empty)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [LINE_W-1:0] mk(input logic [31:0] s);
    return {s, s ^ 32'hA5A5_A5A5, ~s, s + 32'd7};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_line(input string name, input logic [LINE_W-1:0] act,
                            input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver: one buffered upstream op, expected to complete in one cycle
  task automatic do_op(input bit is_wr, input logic [ADDR_W-1:0] a,
                       input logic [LINE_W-1:0] d, input logic [LINE_W-1:0] exp_rd,
                       input string name);
    int lat;
    lat = 0;
    address = a;
    wdata = d;
    write = is_wr;
    read = !is_wr;
    do begin
      tick();
      lat++;
    end while (resp !== 1'b1 && lat < 20);
    check_int({name, " latency"}, lat, 1);
    if (!is_wr) begin
      check_line({name, " rdata"}, rdata, exp_rd);
      check_bit({name, " no pmem_read"}, pmem_read, 1'b0);
    end
    write = 1'b0;
    read = 1'b0;
    tick();
    check_bit({name, " resp one cycle"}, resp, 1'b0);
    tick();
  endtask

  // driver + scoreboard: wait for the next drain write, compare, complete it
  task automatic drain_one(input string name);
    logic [W-1:0] e;
    int n;
    n = 0;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: expected queue empty", name);
      return;
    end
    e = exp_q.pop_front();
    while (pmem_write !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check_bit({name, " pmem_write"}, pmem_write, 1'b1);
    check_bit({name, " pmem_read low"}, pmem_read, 1'b0);
    check_line({name, " pmem_address"}, LINE_W'(pmem_address), LINE_W'(e[W-1:LINE_W]));
    check_line({name, " pmem_wdata"}, pmem_wdata, e[LINE_W-1:0]);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    check_bit({name, " pmem_write dropped"}, pmem_write, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    read = 1'b0;
    write = 1'b0;
    address = '0;
    wdata = '0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    tick();
    tick();
    check_bit("reset resp", resp, 1'b0);
    check_bit("reset pmem_read", pmem_read, 1'b0);
    check_bit("reset pmem_write", pmem_write, 1'b0);
    check_line("reset rdata", rdata, '0);
    check_line("reset pmem_address", LINE_W'(pmem_address), '0);
    check_line("reset pmem_wdata", pmem_wdata, '0);
    check_bit("reset empty", empty, 1'b1);
    check_bit("reset full", full, 1'b0);
    reset = 1'b0;
    tick();

    // basic writeback
    do_op(1'b1, 16'h1230, mk(32'hAAAA_0001), '0, "t1 write");
    check_bit("t1 empty after write", empty, 1'b0);
    exp_q.push_back({16'h1230, mk(32'hAAAA_0001)});
    drain_one("t1 drain");
    check_bit("t1 empty after drain", empty, 1'b1);

    // table: forwarding, duplicates behind draining head, coalescing
    tbl[0]  = '{1'b1, 16'h2000, mk(32'hB000_0000), '0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 16'h2008, '0, mk(32'hB000_0000), 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 16'h2100, mk(32'hC000_0001), '0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 16'h2000, mk(32'hB000_0002), '0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 16'h2004, '0, mk(32'hB000_0002), 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 16'h2100, mk(32'hC000_0002), '0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 16'h2100, '0, mk(32'hC000_0002), 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 16'h2200, mk(32'hD000_0000), '0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 16'h220C, '0, mk(32'hD000_0000), 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 16'h2000, '0, mk(32'hB000_0002), 1'b1, 1'b0};
    tbl[10] = '{1'b1, 16'h2100, mk(32'hC000_0003), '0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 16'h210F, '0, mk(32'hC000_0003), 1'b1, 1'b0};
    for (int i = 0; i < 12; i++) begin
      do_op(tbl[i].is_wr, tbl[i].a, tbl[i].d, tbl[i].exp_rd, $sformatf("tbl[%0d]", i));
      check_bit($sformatf("tbl[%0d] full", i), full, tbl[i].exp_full);
      check_bit($sformatf("tbl[%0d] empty", i), empty, tbl[i].exp_empty);
    end
    exp_q.push_back({16'h2000, mk(32'hB000_0000)});
    exp_q.push_back({16'h2100, mk(32'hC000_0003)});
    exp_q.push_back({16'h2000, mk(32'hB000_0002)});
    exp_q.push_back({16'h2200, mk(32'hD000_0000)});
    for (int i = 0; i < 4; i++) drain_one($sformatf("tbl drain %0d", i));
    check_bit("tbl empty after drain", empty, 1'b1);

    // full stall, accepted after a pop
    do_op(1'b1, 16'h0010, mk(32'h0000_0010), '0, "t2 w10");
    do_op(1'b1, 16'h0020, mk(32'h0000_0020), '0, "t2 w20");
    do_op(1'b1, 16'h0030, mk(32'h0000_0030), '0, "t2 w30");
    do_op(1'b1, 16'h0040, mk(32'h0000_0040), '0, "t2 w40");
    check_bit("t2 full", full, 1'b1);
    check_line("t2 head addr", LINE_W'(pmem_address), LINE_W'(16'h0010));
    check_line("t2 head data", pmem_wdata, mk(32'h0000_0010));
    address = 16'h0050;
    wdata = mk(32'h0000_0050);
    write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_bit($sformatf("t2 stall resp %0d", i), resp, 1'b0);
    end
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    check_bit("t2 resp in pop cycle", resp, 1'b0);
    check_bit("t2 not full after pop", full, 1'b0);
    tick();
    check_bit("t2 resp after pop", resp, 1'b1);
    check_bit("t2 full again", full, 1'b1);
    write = 1'b0;
    tick();
    tick();
    exp_q.push_back({16'h0020, mk(32'h0000_0020)});
    exp_q.push_back({16'h0030, mk(32'h0000_0030)});
    exp_q.push_back({16'h0040, mk(32'h0000_0040)});
    exp_q.push_back({16'h0050, mk(32'h0000_0050)});
    for (int i = 0; i < 4; i++) drain_one($sformatf("t2 drain %0d", i));
    check_bit("t2 empty", empty, 1'b1);

    // read miss overtakes a queued writeback
    do_op(1'b1, 16'h2F00, mk(32'hE000_0000), '0, "t4 w2f00");
    do_op(1'b1, 16'h3000, mk(32'hF000_0000), '0, "t4 w3000");
    address = 16'h4000;
    read = 1'b1;
    tick();
    check_bit("t4 no resp yet", resp, 1'b0);
    check_bit("t4 read waits for drain", pmem_read, 1'b0);
    check_line("t4 inflight drain addr", LINE_W'(pmem_address), LINE_W'(16'h2F00));
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    check_bit("t4 drain popped", pmem_write, 1'b0);
    tick();
    check_bit("t4 pmem_read issued", pmem_read, 1'b1);
    check_bit("t4 pmem_write held off", pmem_write, 1'b0);
    check_line("t4 pmem_read addr", LINE_W'(pmem_address), LINE_W'(16'h4000));
    tick();
    check_bit("t4 still no pmem_write", pmem_write, 1'b0);
    pmem_rdata = mk(32'h1234_5678);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    check_bit("t4 resp", resp, 1'b1);
    check_line("t4 rdata", rdata, mk(32'h1234_5678));
    check_bit("t4 pmem_read dropped", pmem_read, 1'b0);
    read = 1'b0;
    tick();
    tick();
    exp_q.push_back({16'h3000, mk(32'hF000_0000)});
    drain_one("t4 drain");
    check_bit("t4 empty", empty, 1'b1);

    // coalesce behind a different draining head
    do_op(1'b1, 16'h4F00, mk(32'h4F00_0000), '0, "t5 w4f00");
    do_op(1'b1, 16'h5000, mk(32'hC0C0_0000), '0, "t5 wC");
    do_op(1'b1, 16'h5000, mk(32'hD0D0_0000), '0, "t5 wD");
    do_op(1'b0, 16'h5000, '0, mk(32'hD0D0_0000), "t5 rd");
    exp_q.push_back({16'h4F00, mk(32'h4F00_0000)});
    exp_q.push_back({16'h5000, mk(32'hD0D0_0000)});
    drain_one("t5 drain 0");
    drain_one("t5 drain 1");
    check_bit("t5 empty", empty, 1'b1);
    tick();
    tick();
    check_bit("t5 no extra drain", pmem_write, 1'b0);

    // reset mid-drain
    do_op(1'b1, 16'h6000, mk(32'h6000_0000), '0, "t6 w0");
    do_op(1'b1, 16'h6100, mk(32'h6100_0000), '0, "t6 w1");
    do_op(1'b1, 16'h6200, mk(32'h6200_0000), '0, "t6 w2");
    check_bit("t6 draining", pmem_write, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_bit("t6 pmem_write cleared", pmem_write, 1'b0);
    check_bit("t6 empty", empty, 1'b1);
    check_bit("t6 full", full, 1'b0);
    check_bit("t6 resp", resp, 1'b0);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    check_bit("t6 late resp no pop", empty, 1'b1);
    check_bit("t6 late resp no write", pmem_write, 1'b0);
    tick();
    check_bit("t6 stays idle", pmem_write, 1'b0);
    do_op(1'b1, 16'h7000, mk(32'h7000_0000), '0, "t6 w7000");
    exp_q.push_back({16'h7000, mk(32'h7000_0000)});
    drain_one("t6 drain");
    check_bit("t6 final empty", empty, 1'b1);
    check_int("scoreboard leftovers", exp_q.size(), 0);

    // report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
